// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0013;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

   function automatic logic [31:0] add4(input logic [31:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch stage, instruction memory, hazard unit and decoder.
interface fetch_if;

   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] memAddress;
   logic [31:0] instruction;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        halted;

   modport master (
      input  stall, branch_taken, branch_target, instruction,
      output memAddress, if_pc, if_instr, if_valid, halted
   );

   modport slave (
      output stall, branch_taken, branch_target, instruction,
      input  memAddress, if_pc, if_instr, if_valid, halted
   );

endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: redirect, hold or sequential increment.
module next_pc_sel
   import fetch_pkg::*;
(
   input  logic [31:0]  i_pc,
   input  logic         i_branch_taken,
   input  logic [31:0]  i_branch_target,
   input  logic         i_stall,
   input  logic         i_halt_hit,
   input  fetch_state_t i_state,
   output logic [31:0]  o_next_pc
);

   always_comb begin
      o_next_pc = i_pc;
      if (i_state == RUN) begin
         // Redirect wins over stall and over a wrong-path halt word.
         if (i_branch_taken) begin
            o_next_pc = {i_branch_target[31:2], 2'b00};
         end else if (!i_stall && !i_halt_hit) begin
            o_next_pc = add4(i_pc);
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, memory address, IF/ID register, halt FSM.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
   parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
)(
   input  logic clk,
   input  logic reset,
   fetch_if.master bus
);

   logic [31:0]  r_pc;
   fetch_state_t r_state;
   logic         r_halted;
   ifid_t        r_ifid;
   logic [31:0]  w_next_pc;
   logic         w_halt_hit;

   assign w_halt_hit = (bus.instruction == HALT_WORD);

   next_pc_sel u_next_pc_sel (
      .i_pc            (r_pc),
      .i_branch_taken  (bus.branch_taken),
      .i_branch_target (bus.branch_target),
      .i_stall         (bus.stall),
      .i_halt_hit      (w_halt_hit),
      .i_state         (r_state),
      .o_next_pc       (w_next_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_state  <= RUN;
         r_halted <= 1'b0;
         r_ifid   <= '{pc: 32'h0, instr: NOP_WORD, valid: 1'b0};
      end else if (r_state == RUN) begin
         r_pc <= w_next_pc;
         if (bus.branch_taken) begin
            r_ifid <= '{pc: r_pc, instr: NOP_WORD, valid: 1'b0};
         end else if (bus.stall) begin
            r_ifid <= r_ifid;
         end else if (w_halt_hit) begin
            r_ifid   <= '{pc: r_pc, instr: NOP_WORD, valid: 1'b0};
            r_state  <= HALT;
            r_halted <= 1'b1;
         end else begin
            r_ifid <= '{pc: r_pc, instr: bus.instruction, valid: 1'b1};
         end
      end else begin
         // Halted: everything frozen until reset, IF/ID never valid.
         r_ifid.valid <= 1'b0;
         r_halted     <= 1'b1;
      end
   end

   assign bus.memAddress = r_pc;
   assign bus.if_pc      = r_ifid.pc;
   assign bus.if_instr   = r_ifid.instr;
   assign bus.if_valid   = r_ifid.valid;
   assign bus.halted     = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

   logic clk;
   logic reset;
   logic reset2;
   int   checks;
   int   failures;

   logic [31:0] mem [0:15];

   fetch_if bus();
   fetch_if bus2();

   fetch_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk   (clk),
      .reset (reset2),
      .bus   (bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Words above 0x3C read as NOP so the bench never halts by accident there.
   assign bus.instruction  = (bus.memAddress < 32'h40) ? mem[bus.memAddress[5:2]] : 32'h0000_0013;
   assign bus2.instruction = 32'h0000_0013;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013;
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      mem[2] = 32'h0020_81B3;
      mem[3] = 32'h0010_0193;
      mem[4] = 32'h0000_0000;
      mem[8] = 32'h0030_0213;

      reset = 1'b1;
      reset2 = 1'b1;
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = 32'h0;
      step();
      reset = 1'b0;
      check("rst_addr",   bus.memAddress, 32'h0);
      check("rst_ifpc",   bus.if_pc, 32'h0);
      check("rst_instr",  bus.if_instr, 32'h0000_0013);
      check("rst_valid",  {31'b0, bus.if_valid}, 32'h0);
      check("rst_halted", {31'b0, bus.halted}, 32'h0);

      // Free run
      step();
      check("run0_addr",  bus.memAddress, 32'h4);
      check("run0_ifpc",  bus.if_pc, 32'h0);
      check("run0_instr", bus.if_instr, 32'h0050_0093);
      check("run0_valid", {31'b0, bus.if_valid}, 32'h1);
      step();
      check("run1_addr",  bus.memAddress, 32'h8);
      check("run1_ifpc",  bus.if_pc, 32'h4);
      check("run1_instr", bus.if_instr, 32'h00A0_0113);

      // Two-cycle stall at pc=8
      bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_addr",  bus.memAddress, 32'h8);
         check("stall_ifpc",  bus.if_pc, 32'h4);
         check("stall_instr", bus.if_instr, 32'h00A0_0113);
         check("stall_valid", {31'b0, bus.if_valid}, 32'h1);
      end
      bus.stall = 1'b0;
      step();
      check("resume_addr",  bus.memAddress, 32'hC);
      check("resume_ifpc",  bus.if_pc, 32'h8);
      check("resume_instr", bus.if_instr, 32'h0020_81B3);

      // Branch at pc=12 overriding a stall, misaligned target
      bus.stall = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h23;
      step();
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      check("br_addr",  bus.memAddress, 32'h20);
      check("br_valid", {31'b0, bus.if_valid}, 32'h0);
      check("br_instr", bus.if_instr, 32'h0000_0013);
      check("br_ifpc",  bus.if_pc, 32'hC);
      step();
      check("br_next_addr",  bus.memAddress, 32'h24);
      check("br_next_ifpc",  bus.if_pc, 32'h20);
      check("br_next_instr", bus.if_instr, 32'h0030_0213);
      check("br_next_valid", {31'b0, bus.if_valid}, 32'h1);

      // Halt on zero word at 16
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("pre_halt_addr", bus.memAddress, 32'h10);
      check("pre_halt_flag", {31'b0, bus.halted}, 32'h0);
      step();
      check("halt_flag",  {31'b0, bus.halted}, 32'h1);
      check("halt_addr",  bus.memAddress, 32'h10);
      check("halt_valid", {31'b0, bus.if_valid}, 32'h0);
      check("halt_instr", bus.if_instr, 32'h0000_0013);
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h0;
      step();
      step();
      bus.branch_taken = 1'b0;
      check("halt_br_addr", bus.memAddress, 32'h10);
      check("halt_br_flag", {31'b0, bus.halted}, 32'h1);
      check("halt_br_valid", {31'b0, bus.if_valid}, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("unhalt_addr", bus.memAddress, 32'h0);
      check("unhalt_flag", {31'b0, bus.halted}, 32'h0);

      // Halt word seen together with a branch is wrong-path
      for (int i = 0; i < 4; i++) step();
      check("wp_pre_addr", bus.memAddress, 32'h10);
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h40;
      step();
      bus.branch_taken = 1'b0;
      check("wp_flag", {31'b0, bus.halted}, 32'h0);
      check("wp_addr", bus.memAddress, 32'h40);
      step();
      check("wp_next_addr",  bus.memAddress, 32'h44);
      check("wp_next_ifpc",  bus.if_pc, 32'h40);
      check("wp_next_valid", {31'b0, bus.if_valid}, 32'h1);

      // PC wrap from a high reset vector
      reset2 = 1'b1;
      step();
      reset2 = 1'b0;
      bus2.stall = 1'b0;
      bus2.branch_taken = 1'b0;
      bus2.branch_target = 32'h0;
      check("wrap0_addr", bus2.memAddress, 32'hFFFF_FFF8);
      step();
      check("wrap1_addr", bus2.memAddress, 32'hFFFF_FFFC);
      step();
      check("wrap2_addr", bus2.memAddress, 32'h0000_0000);
      check("wrap2_ifpc", bus2.if_pc, 32'hFFFF_FFFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
